// File: rtl/mem_access_sched.sv
// mem_access_sched: MEM-stage load/store sequencer onto an ack-based data port; DMA sharing under `MEM_SCHED_DMA_EN.
// Latency: grant on the request edge, >=1 busy cycle, then CPU_DONE (CPU) or a dma_done pulse (DMA).
// Backpressure: StallM freezes the pipeline while a CPU access is pending; dma_req simply waits in IDLE.
module mem_access_sched #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        RST,
  input  logic        MemWriteM,
  input  logic        MemtoRegM,
  input  logic [31:0] ALUOutM,
  input  logic [31:0] WriteDataM,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  output logic        dma_gnt,
  output logic        dma_done,
  output logic [31:0] dma_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic [31:0] ReadDataM,
  output logic        StallM,
  output logic        mem_err
);

  typedef enum logic [1:0] {IDLE, CPU_BUSY, DMA_BUSY, CPU_DONE} state_e;

  localparam logic [7:0]  TO_LAST = 8'(TIMEOUT - 1);
  localparam logic [31:0] TO_DATA = 32'hDEAD_BEEF;

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic        mem_err_q, mem_err_d;
  logic        dma_done_q, dma_done_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] dma_rdata_q, dma_rdata_d;
  logic        cpu_rq, grant_dma, finish;
  logic [31:0] resp_data;

  assign cpu_rq = MemWriteM | MemtoRegM;

`ifdef MEM_SCHED_DMA_EN
  // dma_prio_q: DMA wins the next contested grant; cleared at reset so the CPU wins first.
  logic dma_prio_q, dma_prio_d;

  assign grant_dma = dma_req & (~cpu_rq | dma_prio_q);

  always_comb begin
    dma_prio_d = dma_prio_q;
    if (state_q == IDLE && (cpu_rq || dma_req)) begin
      dma_prio_d = ~grant_dma;
    end
  end

  always_ff @(posedge clk) begin
    if (RST) dma_prio_q <= 1'b0;
    else     dma_prio_q <= dma_prio_d;
  end

  assign dma_gnt   = (state_q == DMA_BUSY);
  assign dma_done  = dma_done_q;
  assign dma_rdata = dma_rdata_q;
`else
  logic dma_unused;
  assign dma_unused = ^{dma_req, dma_done_q, dma_rdata_q};
  assign grant_dma  = 1'b0;
  assign dma_gnt    = 1'b0;
  assign dma_done   = 1'b0;
  assign dma_rdata  = 32'h0;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_err_d   = mem_err_q;
    rdata_d     = rdata_q;
    dma_rdata_d = dma_rdata_q;
    dma_done_d  = 1'b0;
    finish      = 1'b0;
    resp_data   = mem_rdata;

    case (state_q)
      IDLE: begin
        if (grant_dma) begin
          state_d     = DMA_BUSY;
          mem_req_d   = 1'b1;
          mem_we_d    = dma_we;
          mem_addr_d  = dma_addr;
          mem_wdata_d = dma_wdata;
          cnt_d       = 8'd0;
        end else if (cpu_rq) begin
          state_d     = CPU_BUSY;
          mem_req_d   = 1'b1;
          mem_we_d    = MemWriteM;
          mem_addr_d  = ALUOutM;
          mem_wdata_d = WriteDataM;
          cnt_d       = 8'd0;
        end
      end

      CPU_BUSY, DMA_BUSY: begin
        // An ack in the timeout cycle wins: the access completes cleanly.
        if (mem_ack) begin
          finish = 1'b1;
        end else if (cnt_q == TO_LAST) begin
          finish    = 1'b1;
          resp_data = TO_DATA;
          mem_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end

        if (finish) begin
          mem_req_d = 1'b0;
          if (state_q == CPU_BUSY) begin
            state_d = CPU_DONE;
            if (!mem_we_q) rdata_d = resp_data;
          end else begin
            state_d    = IDLE;
            dma_done_d = 1'b1;
            if (!mem_we_q) dma_rdata_d = resp_data;
          end
        end
      end

      CPU_DONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      state_q     <= IDLE;
      cnt_q       <= 8'd0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'h0;
      mem_wdata_q <= 32'h0;
      mem_err_q   <= 1'b0;
      rdata_q     <= 32'h0;
      dma_rdata_q <= 32'h0;
      dma_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_err_q   <= mem_err_d;
      rdata_q     <= rdata_d;
      dma_rdata_q <= dma_rdata_d;
      dma_done_q  <= dma_done_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_err   = mem_err_q;
  assign ReadDataM = rdata_q;
  assign StallM    = cpu_rq & (state_q != CPU_DONE);

endmodule

// File: tb/tb_mem_access_sched.sv
// Bench for mem_access_sched: directed scenarios plus randomized accesses checked against a transaction-level model.
module tb_mem_access_sched;
  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        RST, MemWriteM, MemtoRegM, dma_req, dma_we, mem_ack;
  logic [31:0] ALUOutM, WriteDataM, dma_addr, dma_wdata, mem_rdata;
  logic        dma_gnt, dma_done, mem_req, mem_we, StallM, mem_err;
  logic [31:0] dma_rdata, mem_addr, mem_wdata, ReadDataM;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] exp_rd = 32'h0;
  logic [31:0] exp_dma_rd = 32'h0;
  logic        exp_err = 1'b0;

  mem_access_sched #(.TIMEOUT(TO)) dut (
    .clk(clk), .RST(RST), .MemWriteM(MemWriteM), .MemtoRegM(MemtoRegM),
    .ALUOutM(ALUOutM), .WriteDataM(WriteDataM), .dma_req(dma_req), .dma_we(dma_we),
    .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_gnt(dma_gnt), .dma_done(dma_done),
    .dma_rdata(dma_rdata), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .ReadDataM(ReadDataM),
    .StallM(StallM), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // One CPU access; dly = busy cycles without ack before the ack (>= TO means never ack).
  task automatic cpu_op(input logic wr, input logic ld, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] rd, input int dly);
    int busy = 0;
    int stalls = 0;
    int fin;
    bit ok = 1'b1;
    bit done = 1'b0;
    fin = (dly < TO) ? dly : TO - 1;
    @(posedge clk); #1;
    MemWriteM = wr; MemtoRegM = ld; ALUOutM = addr; WriteDataM = wdata; mem_ack = 1'b0;
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      if (!StallM) begin done = 1'b1; break; end
      stalls++;
      if (dma_gnt || dma_done) ok = 1'b0;
      if (mem_req) begin
        if (mem_we !== wr || mem_addr !== addr || mem_wdata !== wdata) ok = 1'b0;
        if (busy == fin && dly < TO) begin mem_ack = 1'b1; mem_rdata = rd; end
        else mem_rdata = $urandom;
        busy++;
      end
      @(posedge clk); #1;
      mem_ack = 1'b0;
    end
    if (!wr) exp_rd = (dly < TO) ? rd : 32'hDEADBEEF;
    if (dly >= TO) exp_err = 1'b1;
    chk("cpu_done_reached", 32'(done), 32'd1);
    chk("cpu_stall_cycles", 32'(stalls), 32'(fin + 2));
    chk("cpu_busy_cycles", 32'(busy), 32'(fin + 1));
    chk("cpu_port_hold", 32'(ok), 32'd1);
    chk("cpu_ReadDataM", ReadDataM, exp_rd);
    chk("cpu_req_dropped", 32'(mem_req), 32'd0);
    chk("cpu_mem_err", 32'(mem_err), 32'(exp_err));
  endtask

  task automatic mid_reset();
    int busy = 0;
    bit ok = 1'b1;
    @(posedge clk); #1;
`ifdef MEM_SCHED_DMA_EN
    MemWriteM = 1'b0; MemtoRegM = 1'b0; dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h300;
`else
    MemWriteM = 1'b0; MemtoRegM = 1'b1; ALUOutM = 32'h300;
`endif
    mem_ack = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (mem_req) busy++;
      if (busy == 2) break;
      @(posedge clk); #1;
    end
    chk("rst_reached_busy2", 32'(busy), 32'd2);
    RST = 1'b1; dma_req = 1'b0; MemtoRegM = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h5A5A5A5A;
    @(posedge clk); #1;
    RST = 1'b0; mem_ack = 1'b0;
    exp_rd = 32'h0; exp_dma_rd = 32'h0; exp_err = 1'b0;
    @(negedge clk);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_dma_gnt", 32'(dma_gnt), 32'd0);
    chk("rst_dma_rdata", dma_rdata, 32'h0);
    chk("rst_ReadDataM", ReadDataM, 32'h0);
    chk("rst_mem_err", 32'(mem_err), 32'd0);
    for (int c = 0; c < 5; c++) begin
      if (dma_done || mem_req || StallM) ok = 1'b0;
      @(negedge clk);
    end
    chk("rst_no_done_pulse", 32'(ok), 32'd1);
  endtask

`ifdef MEM_SCHED_DMA_EN
  task automatic dma_op(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rd, input int dly);
    int busy = 0;
    int fin;
    bit ok = 1'b1;
    bit done = 1'b0;
    logic [31:0] cpu_rd_before;
    fin = (dly < TO) ? dly : TO - 1;
    cpu_rd_before = exp_rd;
    @(posedge clk); #1;
    MemWriteM = 1'b0; MemtoRegM = 1'b0; dma_req = 1'b1; dma_we = we;
    dma_addr = addr; dma_wdata = wdata; mem_ack = 1'b0;
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      if (dma_done) begin done = 1'b1; break; end
      if (StallM) ok = 1'b0;
      if (mem_req) begin
        if (!dma_gnt || mem_we !== we || mem_addr !== addr || mem_wdata !== wdata) ok = 1'b0;
        mem_rdata = $urandom;
        if (busy == fin) begin
          dma_req = 1'b0;
          if (dly < TO) begin mem_ack = 1'b1; mem_rdata = rd; end
        end
        busy++;
      end
      @(posedge clk); #1;
      mem_ack = 1'b0;
    end
    if (!we) exp_dma_rd = (dly < TO) ? rd : 32'hDEADBEEF;
    if (dly >= TO) exp_err = 1'b1;
    chk("dma_done_seen", 32'(done), 32'd1);
    chk("dma_busy_cycles", 32'(busy), 32'(fin + 1));
    chk("dma_port_hold", 32'(ok), 32'd1);
    chk("dma_rdata", dma_rdata, exp_dma_rd);
    chk("dma_gnt_released", 32'(dma_gnt), 32'd0);
    chk("dma_mem_err", 32'(mem_err), 32'(exp_err));
    chk("dma_cpu_rd_untouched", ReadDataM, cpu_rd_before);
    @(posedge clk); #1;
    @(negedge clk);
    chk("dma_done_one_pulse", 32'(dma_done), 32'd0);
  endtask

  task automatic rr_test();
    bit exp_dma[6];
    int last = 0;  // 0: nothing granted yet, 1: CPU, 2: DMA
    int g = 0;
    int dones = 0;
    bit ok = 1'b1;
    for (int i = 0; i < 6; i++) begin
      exp_dma[i] = (last == 1);
      last = exp_dma[i] ? 2 : 1;
      if (exp_dma[i]) exp_dma_rd = 32'hD000_0000 + 32'(i);
      else            exp_rd     = 32'hC000_0000 + 32'(i);
    end
    @(posedge clk); #1;
    MemWriteM = 1'b0; MemtoRegM = 1'b1; ALUOutM = 32'h100; WriteDataM = 32'h0;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h200; dma_wdata = 32'h0;
    for (int c = 0; c < 64 && g < 6; c++) begin
      @(negedge clk);
      if (dma_done) dones++;
      if (mem_req) begin
        chk($sformatf("rr_grant%0d_is_dma", g), 32'(dma_gnt), 32'(exp_dma[g]));
        if (dma_gnt && !StallM) ok = 1'b0;
        mem_ack = 1'b1;
        mem_rdata = exp_dma[g] ? 32'hD000_0000 + 32'(g) : 32'hC000_0000 + 32'(g);
        g++;
      end
      @(posedge clk); #1;
      mem_ack = 1'b0;
    end
    MemtoRegM = 1'b0; dma_req = 1'b0;
    @(negedge clk);
    if (dma_done) dones++;
    chk("rr_grants", 32'(g), 32'd6);
    chk("rr_dma_done_count", 32'(dones), 32'd3);
    chk("rr_stall_during_dma", 32'(ok), 32'd1);
    chk("rr_ReadDataM", ReadDataM, exp_rd);
    chk("rr_dma_rdata", dma_rdata, exp_dma_rd);
  endtask
`endif

  initial begin
    int r, dly;
    RST = 1'b1; MemWriteM = 1'b0; MemtoRegM = 1'b1; ALUOutM = 32'h0; WriteDataM = 32'h0;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = 32'h0; dma_wdata = 32'h0;
    mem_ack = 1'b0; mem_rdata = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_mem_req", 32'(mem_req), 32'd0);
    chk("reset_mem_we", 32'(mem_we), 32'd0);
    chk("reset_mem_addr", mem_addr, 32'h0);
    chk("reset_mem_wdata", mem_wdata, 32'h0);
    chk("reset_ReadDataM", ReadDataM, 32'h0);
    chk("reset_mem_err", 32'(mem_err), 32'd0);
    chk("reset_dma_gnt", 32'(dma_gnt), 32'd0);
    chk("reset_dma_done", 32'(dma_done), 32'd0);
    chk("reset_dma_rdata", dma_rdata, 32'h0);
    chk("reset_StallM_formula", 32'(StallM), 32'd1);
    @(posedge clk); #1;
    RST = 1'b0; MemtoRegM = 1'b0;

    cpu_op(1'b0, 1'b1, 32'h0000_0040, 32'h0, 32'h1234_5678, 0);
    cpu_op(1'b1, 1'b0, 32'h0000_0080, 32'hCAFE_F00D, 32'h0BAD_F00D, 3);
    cpu_op(1'b1, 1'b1, 32'h0000_0084, 32'h1111_2222, 32'h3333_4444, 1);

    // Stray ack while idle must be ignored.
    @(posedge clk); #1;
    MemWriteM = 1'b0; MemtoRegM = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h0BAD_0BAD;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    @(negedge clk);
    chk("idle_ack_ReadDataM", ReadDataM, exp_rd);
    chk("idle_ack_mem_req", 32'(mem_req), 32'd0);
    chk("idle_ack_dma_done", 32'(dma_done), 32'd0);

    cpu_op(1'b0, 1'b1, 32'h0000_0100, 32'h0, 32'hABCD_0001, TO - 1);
    cpu_op(1'b0, 1'b1, 32'h0000_0104, 32'h0, 32'hABCD_0002, TO + 5);
    cpu_op(1'b0, 1'b1, 32'h0000_0108, 32'h0, 32'hABCD_0003, 1);

`ifdef MEM_SCHED_DMA_EN
    rr_test();
    dma_op(1'b0, 32'h0000_2000, 32'h0, 32'h5555_AAAA, 2);
    dma_op(1'b1, 32'h0000_2004, 32'h7777_8888, 32'h0, 0);
    dma_op(1'b0, 32'h0000_2008, 32'h0, 32'h1212_3434, TO + 2);
`else
    dma_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cpu_op(1'b0, 1'b1, 32'h0000_0040 + 32'(4 * i), 32'h0, 32'h9000_0000 + 32'(i), 0);
    end
    dma_req = 1'b0;
`endif

    for (int i = 0; i < 20; i++) begin
      r = int'($urandom_range(0, 9));
      dly = (r == 9) ? TO + 1 : (r == 8) ? TO - 1 : r % 5;
`ifdef MEM_SCHED_DMA_EN
      if ($urandom_range(0, 2) == 0) begin
        dma_op(1'($urandom_range(0, 1)), $urandom, $urandom, $urandom, dly);
        continue;
      end
`endif
      case ($urandom_range(0, 2))
        0:       cpu_op(1'b0, 1'b1, $urandom, $urandom, $urandom, dly);
        1:       cpu_op(1'b1, 1'b0, $urandom, $urandom, $urandom, dly);
        default: cpu_op(1'b1, 1'b1, $urandom, $urandom, $urandom, dly);
      endcase
    end

    mid_reset();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
